// File: rtl/ifm_read_responder.sv
// IFM read responder: turns accepted byte-address requests into SRAM word reads and
// returns the words in order through a credit-protected response FIFO.
module ifm_read_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int IW = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  flush,
    output logic                  mem_en,
    output logic [IW-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;
    state_t state_q, state_d;

    logic [RD_LATENCY-1:0] vld_p, err_p, vld_next, err_next;
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   head;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, inflight, credit_used;
    logic [ADDR_WIDTH-1:0] widx;
    logic                  req_err, accept, push, pop;

    always_comb begin
        widx     = req_addr >> 2;
        req_err  = (req_addr[1:0] != 2'b00) || (widx >= DEPTH_A);
        mem_addr = widx[IW-1:0];
        inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            inflight = inflight + CW'(vld_p[k]);
        end
    end

    assign pop         = (count_q != '0) && resp_ready && !flush;
    assign push        = vld_p[RD_LATENCY-1] && !flush;
    // A same-cycle pop frees its slot before the credit check.
    assign credit_used = inflight + count_q - CW'(pop);

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            ST_RUN: begin
                req_ready = rst_n && !flush && (credit_used < CW'(FIFO_DEPTH));
                if (flush) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_RUN;
        endcase
    end

    assign accept = req_valid && req_ready;
    assign mem_en = accept && !req_err;

    // Stage p0..p(L-1): tags ride alongside the SRAM read latency.
    always_comb begin
        vld_next    = '0;
        err_next    = '0;
        vld_next[0] = accept;
        err_next[0] = req_err;
        for (int k = 1; k < RD_LATENCY; k++) begin
            vld_next[k] = vld_p[k-1];
            err_next[k] = err_p[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            vld_p    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                vld_p    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                vld_p <= vld_next;
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Last tag stage -> FIFO: error entries carry zero data.
    always_ff @(posedge clk) begin
        err_p <= err_next;
        if (push) begin
            fifo_mem[wr_ptr_q] <= {err_p[RD_LATENCY-1],
                                   mem_rdata & {DATA_WIDTH{!err_p[RD_LATENCY-1]}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) assert (count_q < CW'(FIFO_DEPTH));
    end

    assign head       = fifo_mem[rd_ptr_q];
    assign resp_valid = (count_q != '0);
    assign resp_data  = resp_valid ? head[DATA_WIDTH-1:0] : '0;
    assign resp_err   = resp_valid && head[DATA_WIDTH];
    assign busy       = (inflight != '0) || resp_valid;

endmodule
